// File: rtl/writeback_unit.sv
// writeback_unit
// Writeback stage and sole driver of the register file write port.
// Accepts retiring instructions from the memory stage and, for loads, waits
// for the data-memory read response. Load data is extracted from the aligned
// doubleword and then sign- or zero-extended. Each instruction that writes a
// register produces exactly one registered write pulse.
//
// Ports
//   clk, reset         : posedge clock, synchronous active-high reset
//   InValid / InReady  : handshake from the memory stage
//   Flush              : discard the instruction presented this cycle
//   InRegWrite, InMemToReg, InJump, InRD, InFunct3 : instruction control
//   ALUResult          : ALU result / load address (bits [2:0] = byte offset)
//   PCPlus4            : link value for JAL/JALR
//   MemRdata, MemRdValid : data-memory read response
//   RegWrite, RD, WriteData : register file write port (registered)
module writeback_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic            Flush,
  input  logic            InRegWrite,
  input  logic            InMemToReg,
  input  logic            InJump,
  input  logic [4:0]      InRD,
  input  logic [2:0]      InFunct3,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] PCPlus4,
  input  logic [XLEN-1:0] MemRdata,
  input  logic            MemRdValid,
  output logic            RegWrite,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] WriteData
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  // Context of the load in flight, captured at transfer.
  logic              ld_we_q, ld_we_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [2:0]        ld_off_q, ld_off_d;

  // Extract the addressed byte/half/word from the aligned doubleword and
  // extend it. Low offset bits below the access size are ignored, so a
  // misaligned access simply reads the naturally aligned container.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [2:0]      f3,
    input logic [2:0]      off,
    input logic [XLEN-1:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[2:1], 4'b0000} +: 16];
    w = d[{off[2], 5'b00000} +: 32];
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_extend = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, h};
      3'b010:  load_extend = {{(XLEN-32){w[31]}}, w};
      3'b110:  load_extend = {{(XLEN-32){1'b0}}, w};
      default: load_extend = d;
    endcase
  endfunction

  // Deasserted during reset so nothing is transferred while the stage clears.
  assign InReady = (state_q == IDLE) & ~reset;

  always_comb begin
    state_d     = state_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    ld_we_d     = ld_we_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;

    case (state_q)
      IDLE: begin
        if (InValid && !Flush) begin
          if (InMemToReg) begin
            ld_we_d     = InRegWrite & (InRD != 5'd0);
            ld_rd_d     = InRD;
            ld_funct3_d = InFunct3;
            ld_off_d    = ALUResult[2:0];
            state_d     = WAIT_LOAD;
          end else if (InRegWrite && (InRD != 5'd0)) begin
            // RD/WriteData only move when a write actually happens, so they
            // hold their last values whenever RegWrite is low.
            reg_write_d = 1'b1;
            rd_d        = InRD;
            wdata_d     = InJump ? PCPlus4 : ALUResult;
          end
        end
      end
      WAIT_LOAD: begin
        // Flush is deliberately not consulted: a load in flight completes.
        if (MemRdValid) begin
          state_d = IDLE;
          if (ld_we_q) begin
            reg_write_d = 1'b1;
            rd_d        = ld_rd_q;
            wdata_d     = load_extend(ld_funct3_q, ld_off_q, MemRdata);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      wdata_q     <= '0;
      ld_we_q     <= 1'b0;
      ld_rd_q     <= 5'd0;
      ld_funct3_q <= 3'd0;
      ld_off_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      ld_we_q     <= ld_we_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign RD        = rd_q;
  assign WriteData = wdata_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit.
module tb_writeback_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            InValid;
  logic            InReady;
  logic            Flush;
  logic            InRegWrite;
  logic            InMemToReg;
  logic            InJump;
  logic [4:0]      InRD;
  logic [2:0]      InFunct3;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] PCPlus4;
  logic [XLEN-1:0] MemRdata;
  logic            MemRdValid;
  logic            RegWrite;
  logic [4:0]      RD;
  logic [XLEN-1:0] WriteData;

  int tests = 0;
  int fails = 0;

  writeback_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .Flush      (Flush),
    .InRegWrite (InRegWrite),
    .InMemToReg (InMemToReg),
    .InJump     (InJump),
    .InRD       (InRD),
    .InFunct3   (InFunct3),
    .ALUResult  (ALUResult),
    .PCPlus4    (PCPlus4),
    .MemRdata   (MemRdata),
    .MemRdValid (MemRdValid),
    .RegWrite   (RegWrite),
    .RD         (RD),
    .WriteData  (WriteData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    InValid    = 1'b0;
    Flush      = 1'b0;
    InRegWrite = 1'b0;
    InMemToReg = 1'b0;
    InJump     = 1'b0;
    InRD       = 5'd0;
    InFunct3   = 3'd0;
    ALUResult  = '0;
    PCPlus4    = '0;
    MemRdValid = 1'b0;
  endtask

  // Issue a load, hold off the response for 'waits' cycles, then deliver it.
  // Returns just after the edge that samples MemRdValid.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] data, input int waits);
    clear_in();
    InValid    = 1'b1;
    InRegWrite = 1'b1;
    InMemToReg = 1'b1;
    InRD       = rd;
    InFunct3   = f3;
    ALUResult  = addr;
    tick();
    clear_in();
    chk({tag, "_busy0"}, 64'(InReady), 64'd0);
    chk({tag, "_nowr0"}, 64'(RegWrite), 64'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, "_busyw"}, 64'(InReady), 64'd0);
      chk({tag, "_nowrw"}, 64'(RegWrite), 64'd0);
    end
    MemRdValid = 1'b1;
    MemRdata   = data;
    tick();
    MemRdValid = 1'b0;
  endtask

  initial begin
    clear_in();
    MemRdata = '0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_rd", 64'(RD), 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    chk("rst_inready", 64'(InReady), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_inready", 64'(InReady), 64'd1);

    // Back-to-back ADD x5 and JAL x1
    InValid = 1'b1; InRegWrite = 1'b1; InRD = 5'd5; ALUResult = 64'h1234;
    tick();
    chk("add_regwrite", 64'(RegWrite), 64'd1);
    chk("add_rd", 64'(RD), 64'd5);
    chk("add_wdata", WriteData, 64'h1234);
    InRD = 5'd1; InJump = 1'b1; PCPlus4 = 64'h100; ALUResult = 64'hDEAD;
    tick();
    chk("jal_regwrite", 64'(RegWrite), 64'd1);
    chk("jal_rd", 64'(RD), 64'd1);
    chk("jal_wdata", WriteData, 64'h100);
    clear_in();
    tick();
    chk("idle_regwrite", 64'(RegWrite), 64'd0);
    chk("idle_rd_hold", 64'(RD), 64'd1);
    chk("idle_wdata_hold", WriteData, 64'h100);

    // LB x7, offset 3, two wait cycles
    do_load("lb", 5'd7, 3'b000, 64'h3, 64'h0000_0000_8000_0000, 2);
    chk("lb_regwrite", 64'(RegWrite), 64'd1);
    chk("lb_rd", 64'(RD), 64'd7);
    chk("lb_wdata", WriteData, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ready_back", 64'(InReady), 64'd1);
    // Stray response while idle must not write
    MemRdValid = 1'b1;
    MemRdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    MemRdValid = 1'b0;
    chk("lb_single_pulse", 64'(RegWrite), 64'd0);
    chk("lb_wdata_hold", WriteData, 64'hFFFF_FFFF_FFFF_FF80);

    // LHU x8, offset 6, zero-wait
    do_load("lhu", 5'd8, 3'b101, 64'h6, 64'hBEEF_0000_0000_0000, 0);
    chk("lhu_regwrite", 64'(RegWrite), 64'd1);
    chk("lhu_rd", 64'(RD), 64'd8);
    chk("lhu_wdata", WriteData, 64'h0000_0000_0000_BEEF);

    // LW x9, offset 4
    do_load("lw", 5'd9, 3'b010, 64'h4, 64'hBEEF_0000_0000_0000, 1);
    chk("lw_regwrite", 64'(RegWrite), 64'd1);
    chk("lw_rd", 64'(RD), 64'd9);
    chk("lw_wdata", WriteData, 64'hFFFF_FFFF_BEEF_0000);

    // LBU x10, offset 7 (zero extension of a byte with MSB set)
    do_load("lbu", 5'd10, 3'b100, 64'h7, 64'h80FF_FFFF_FFFF_FFFF, 0);
    chk("lbu_wdata", WriteData, 64'h0000_0000_0000_0080);

    // LH x11, offset 3 (alignment bit ignored: halfword 1)
    do_load("lh", 5'd11, 3'b001, 64'h3, 64'h0000_0000_9ABC_0000, 0);
    chk("lh_wdata", WriteData, 64'hFFFF_FFFF_FFFF_9ABC);

    // ADD to x0 then LD to x0
    clear_in();
    InValid = 1'b1; InRegWrite = 1'b1; InRD = 5'd0; ALUResult = 64'h77;
    tick();
    chk("add_x0_nowrite", 64'(RegWrite), 64'd0);
    do_load("ld_x0", 5'd0, 3'b011, 64'h0, 64'h1122_3344_5566_7788, 0);
    chk("ld_x0_nowrite", 64'(RegWrite), 64'd0);
    chk("ld_x0_ready", 64'(InReady), 64'd1);
    chk("ld_x0_wdata_hold", WriteData, 64'hFFFF_FFFF_FFFF_9ABC);
    InValid = 1'b1; InRegWrite = 1'b1; InRD = 5'd3; ALUResult = 64'h55;
    tick();
    chk("after_x0_regwrite", 64'(RegWrite), 64'd1);
    chk("after_x0_wdata", WriteData, 64'h55);

    // Flushed ADD produces no write
    InRD = 5'd4; ALUResult = 64'h99; Flush = 1'b1;
    tick();
    chk("flush_nowrite", 64'(RegWrite), 64'd0);
    chk("flush_rd_hold", 64'(RD), 64'd3);
    clear_in();

    // Reset during WAIT_LOAD, then a late response
    InValid = 1'b1; InRegWrite = 1'b1; InMemToReg = 1'b1; InRD = 5'd6; ALUResult = 64'h0;
    tick();
    clear_in();
    chk("rwl_busy", 64'(InReady), 64'd0);
    reset = 1'b1;
    tick();
    chk("rwl_nowrite", 64'(RegWrite), 64'd0);
    chk("rwl_ready_in_reset", 64'(InReady), 64'd0);
    reset = 1'b0;
    #1;
    chk("rwl_ready_after", 64'(InReady), 64'd1);
    MemRdValid = 1'b1;
    MemRdata   = 64'h0000_0000_0000_0042;
    tick();
    MemRdValid = 1'b0;
    chk("rwl_late_nowrite", 64'(RegWrite), 64'd0);
    chk("rwl_ready_stays", 64'(InReady), 64'd1);
    tick();
    chk("rwl_late_nowrite2", 64'(RegWrite), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
